// File: rtl/mem_stage.sv
// Memory stage: drives the data bus for loads/stores, stalls the pipeline
// while an access is outstanding, and registers results into MEM/WB.
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef MASK_WIDTH
`define MASK_WIDTH 2
`define MASK_B 2'd0
`define MASK_H 2'd1
`define MASK_W 2'd2
`endif

module mem_stage (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [`REG_DATA_WIDTH-1:0]    alu_res_mem,
  input  logic [`REG_DATA_WIDTH-1:0]    bypass_op2_mem,
  input  logic [`REG_ADDR_WIDTH-1:0]    rd_addr_mem,
  input  logic                          mem_read_mem,
  input  logic                          mem_write_mem,
  input  logic [`MASK_WIDTH-1:0]        mask_mem,
  input  logic                          unsigned_load_mem,
  input  logic                          reg_write_mem,
  input  logic                          mem_to_reg_mem,
  input  logic                          has_inst_mem,
  input  logic [31:0]                   inst_pc_mem,
  output logic                          dmem_req,
  output logic                          dmem_we,
  output logic [31:0]                   dmem_addr,
  output logic [3:0]                    dmem_be,
  output logic [31:0]                   dmem_wdata,
  input  logic                          dmem_gnt,
  input  logic                          dmem_rvalid,
  input  logic [31:0]                   dmem_rdata,
  output logic                          stall_mem,
  output logic [`REG_DATA_WIDTH-1:0]    alu_res_wb,
  output logic [`REG_DATA_WIDTH-1:0]    mem_data_wb,
  output logic [`REG_ADDR_WIDTH-1:0]    rd_addr_wb,
  output logic                          reg_write_wb,
  output logic                          mem_to_reg_wb,
  output logic                          has_inst_wb,
  output logic [31:0]                   inst_pc_wb,
  output logic                          misalign_wb,
  output logic [1:0]                    state_dbg
);

  // Bus handshake: a request is accepted in the cycle where dmem_req and
  // dmem_gnt are both high; read data returns later with a one-cycle dmem_rvalid.
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, new_wdata;
  logic [3:0]  be_q, be_d, new_be;
  logic [1:0]  off_q, off_d;
  logic [`MASK_WIDTH-1:0] mask_q, mask_d;
  logic        uns_q, uns_d, read_q, read_d;

  logic        access, misalign, go, load_done, cur_read;
  logic [31:0] shifted, load_data;

  logic [31:0] alu_res_q, mem_data_q, inst_pc_q;
  logic [31:0] alu_res_d, mem_data_d, inst_pc_d;
  logic [`REG_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic        reg_write_q, mem_to_reg_q, has_inst_q, misalign_q;
  logic        reg_write_d, mem_to_reg_d, has_inst_d, misalign_d;

  always_comb begin
    access   = has_inst_mem & (mem_read_mem | mem_write_mem);
    misalign = access & (((mask_mem == `MASK_H) & alu_res_mem[0]) |
                         ((mask_mem == `MASK_W) & (alu_res_mem[1:0] != 2'b00)));
    go       = access & ~misalign;
    new_be    = 4'b1111;
    new_wdata = bypass_op2_mem;
    case (mask_mem)
      `MASK_B: begin
        new_be    = 4'b0001 << alu_res_mem[1:0];
        new_wdata = {4{bypass_op2_mem[7:0]}};
      end
      `MASK_H: begin
        new_be    = alu_res_mem[1] ? 4'b1100 : 4'b0011;
        new_wdata = {2{bypass_op2_mem[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    off_d     = off_q;
    mask_d    = mask_q;
    uns_d     = uns_q;
    read_d    = read_q;
    dmem_req  = 1'b0;
    stall_mem = 1'b0;
    load_done = 1'b0;
    case (state_q)
      IDLE: if (go) begin
        dmem_req = 1'b1;
        addr_d   = {alu_res_mem[31:2], 2'b00};
        be_d     = new_be;
        wdata_d  = new_wdata;
        off_d    = alu_res_mem[1:0];
        mask_d   = mask_mem;
        uns_d    = unsigned_load_mem;
        read_d   = mem_read_mem;
        if (!dmem_gnt) begin
          state_d   = REQ;
          stall_mem = 1'b1;
        end else if (mem_read_mem) begin
          state_d   = RESP;
          stall_mem = 1'b1;
        end
      end
      REQ: begin
        dmem_req = 1'b1;
        if (!dmem_gnt) stall_mem = 1'b1;
        else if (read_q) begin
          state_d   = RESP;
          stall_mem = 1'b1;
        end else state_d = IDLE;
      end
      RESP: begin
        if (dmem_rvalid) begin
          state_d   = IDLE;
          load_done = 1'b1;
        end else stall_mem = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // In IDLE the bus sees the live attributes so a grant can land in the issue cycle.
  always_comb begin
    cur_read   = (state_q == IDLE) ? mem_read_mem : read_q;
    dmem_addr  = (state_q == IDLE) ? {alu_res_mem[31:2], 2'b00} : addr_q;
    dmem_be    = (state_q == IDLE) ? new_be : be_q;
    dmem_wdata = (state_q == IDLE) ? new_wdata : wdata_q;
    dmem_we    = dmem_req & ~cur_read;
    state_dbg  = state_q;
  end

  always_comb begin
    shifted   = dmem_rdata >> {off_q, 3'b000};
    load_data = dmem_rdata;
    case (mask_q)
      `MASK_B: load_data = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
      `MASK_H: load_data = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    alu_res_d    = alu_res_mem;
    mem_data_d   = load_done ? load_data : 32'd0;
    rd_addr_d    = rd_addr_mem;
    reg_write_d  = reg_write_mem & ~misalign;
    mem_to_reg_d = mem_to_reg_mem;
    has_inst_d   = has_inst_mem;
    inst_pc_d    = inst_pc_mem;
    misalign_d   = misalign;
    if (stall_mem) begin
      reg_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      has_inst_d   = 1'b0;
      misalign_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      off_q        <= '0;
      mask_q       <= '0;
      uns_q        <= 1'b0;
      read_q       <= 1'b0;
      alu_res_q    <= '0;
      mem_data_q   <= '0;
      rd_addr_q    <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      has_inst_q   <= 1'b0;
      inst_pc_q    <= '0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      off_q        <= off_d;
      mask_q       <= mask_d;
      uns_q        <= uns_d;
      read_q       <= read_d;
      alu_res_q    <= alu_res_d;
      mem_data_q   <= mem_data_d;
      rd_addr_q    <= rd_addr_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      has_inst_q   <= has_inst_d;
      inst_pc_q    <= inst_pc_d;
      misalign_q   <= misalign_d;
    end
  end

  assign alu_res_wb    = alu_res_q;
  assign mem_data_wb   = mem_data_q;
  assign rd_addr_wb    = rd_addr_q;
  assign reg_write_wb  = reg_write_q;
  assign mem_to_reg_wb = mem_to_reg_q;
  assign has_inst_wb   = has_inst_q;
  assign inst_pc_wb    = inst_pc_q;
  assign misalign_wb   = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stores, loads, stalls, misalignment, reset abandon.
`ifndef MASK_WIDTH
`define MASK_WIDTH 2
`define MASK_B 2'd0
`define MASK_H 2'd1
`define MASK_W 2'd2
`endif

module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_res_mem, bypass_op2_mem, inst_pc_mem;
  logic [4:0]  rd_addr_mem;
  logic        mem_read_mem, mem_write_mem, unsigned_load_mem;
  logic        reg_write_mem, mem_to_reg_mem, has_inst_mem;
  logic [1:0]  mask_mem;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stall_mem;
  logic [31:0] alu_res_wb, mem_data_wb, inst_pc_wb;
  logic [4:0]  rd_addr_wb;
  logic        reg_write_wb, mem_to_reg_wb, has_inst_wb, misalign_wb;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  int req_cycles;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .alu_res_mem(alu_res_mem), .bypass_op2_mem(bypass_op2_mem),
    .rd_addr_mem(rd_addr_mem), .mem_read_mem(mem_read_mem),
    .mem_write_mem(mem_write_mem), .mask_mem(mask_mem),
    .unsigned_load_mem(unsigned_load_mem), .reg_write_mem(reg_write_mem),
    .mem_to_reg_mem(mem_to_reg_mem), .has_inst_mem(has_inst_mem),
    .inst_pc_mem(inst_pc_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .stall_mem(stall_mem),
    .alu_res_wb(alu_res_wb), .mem_data_wb(mem_data_wb),
    .rd_addr_wb(rd_addr_wb), .reg_write_wb(reg_write_wb),
    .mem_to_reg_wb(mem_to_reg_wb), .has_inst_wb(has_inst_wb),
    .inst_pc_wb(inst_pc_wb), .misalign_wb(misalign_wb),
    .state_dbg(state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inst();
    alu_res_mem       = '0;
    bypass_op2_mem    = '0;
    inst_pc_mem       = '0;
    rd_addr_mem       = '0;
    mem_read_mem      = 1'b0;
    mem_write_mem     = 1'b0;
    unsigned_load_mem = 1'b0;
    reg_write_mem     = 1'b0;
    mem_to_reg_mem    = 1'b0;
    has_inst_mem      = 1'b0;
    mask_mem          = `MASK_W;
    dmem_gnt          = 1'b0;
    dmem_rvalid       = 1'b0;
    dmem_rdata        = '0;
  endtask

  task automatic set_acc(input logic [31:0] addr, input logic [31:0] data,
                         input logic rd, input logic wr, input logic [1:0] mask,
                         input logic uns, input logic [31:0] pc);
    alu_res_mem       = addr;
    bypass_op2_mem    = data;
    mem_read_mem      = rd;
    mem_write_mem     = wr;
    mask_mem          = mask;
    unsigned_load_mem = uns;
    reg_write_mem     = rd;
    mem_to_reg_mem    = rd;
    rd_addr_mem       = 5'd3;
    has_inst_mem      = 1'b1;
    inst_pc_mem       = pc;
  endtask

  // Load with grant in the issue cycle; gap = RESP cycles before rvalid.
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] mask,
                         input logic uns, input logic [31:0] rdata, input logic [31:0] exp,
                         input int gap);
    set_acc(addr, 32'd0, 1'b1, 1'b0, mask, uns, 32'h44);
    dmem_gnt = 1'b1;
    settle();
    check({tag, "_req"}, 32'(dmem_req), 32'd1);
    check({tag, "_we"}, 32'(dmem_we), 32'd0);
    check({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
    check({tag, "_stall_n"}, 32'(stall_mem), 32'd1);
    step();
    dmem_gnt = 1'b0;
    for (int i = 0; i < gap; i++) begin
      settle();
      check({tag, "_stall_gap"}, 32'(stall_mem), 32'd1);
      check({tag, "_req_resp"}, 32'(dmem_req), 32'd0);
      step();
    end
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdata;
    settle();
    check({tag, "_stall_rv"}, 32'(stall_mem), 32'd0);
    check({tag, "_bubble"}, 32'(has_inst_wb), 32'd0);
    step();
    clear_inst();
    check({tag, "_data"}, mem_data_wb, exp);
    check({tag, "_has_inst"}, 32'(has_inst_wb), 32'd1);
    check({tag, "_reg_write"}, 32'(reg_write_wb), 32'd1);
  endtask

  initial begin
    clear_inst();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    settle();
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_stall", 32'(stall_mem), 32'd0);
    check("rst_has_inst", 32'(has_inst_wb), 32'd0);
    check("rst_pc", inst_pc_wb, 32'd0);
    check("rst_alu", alu_res_wb, 32'd0);

    // store word, immediate grant
    set_acc(32'h100, 32'hDEADBEEF, 1'b0, 1'b1, `MASK_W, 1'b0, 32'h40);
    dmem_gnt = 1'b1;
    settle();
    check("sw_req", 32'(dmem_req), 32'd1);
    check("sw_we", 32'(dmem_we), 32'd1);
    check("sw_addr", dmem_addr, 32'h100);
    check("sw_be", 32'(dmem_be), 32'hF);
    check("sw_wdata", dmem_wdata, 32'hDEADBEEF);
    check("sw_stall", 32'(stall_mem), 32'd0);
    step();
    clear_inst();
    check("sw_has_inst", 32'(has_inst_wb), 32'd1);
    check("sw_pc", inst_pc_wb, 32'h40);
    check("sw_mem_data", mem_data_wb, 32'd0);
    settle();
    check("sw_state", 32'(state_dbg), 32'd0);

    // store byte at offset 2
    set_acc(32'h106, 32'h0000005A, 1'b0, 1'b1, `MASK_B, 1'b0, 32'h48);
    dmem_gnt = 1'b1;
    settle();
    check("sb_be", 32'(dmem_be), 32'h4);
    check("sb_wdata", dmem_wdata, 32'h5A5A5A5A);
    check("sb_addr", dmem_addr, 32'h104);
    step();
    clear_inst();

    do_load("lb_s", 32'h103, `MASK_B, 1'b0, 32'h80FFFFFF, 32'hFFFFFF80, 1);
    do_load("lb_u", 32'h103, `MASK_B, 1'b1, 32'h80FFFFFF, 32'h00000080, 1);
    do_load("lh_s", 32'h102, `MASK_H, 1'b0, 32'h80011234, 32'hFFFF8001, 0);
    do_load("lh_u", 32'h102, `MASK_H, 1'b1, 32'h80011234, 32'h00008001, 0);

    // store half with grant delayed 3 cycles
    req_cycles = 0;
    set_acc(32'h202, 32'h0000ABCD, 1'b0, 1'b1, `MASK_H, 1'b0, 32'h50);
    for (int i = 0; i < 3; i++) begin
      settle();
      if (dmem_req) req_cycles++;
      check("sh_be_hold", 32'(dmem_be), 32'hC);
      check("sh_wdata_hold", dmem_wdata, 32'hABCDABCD);
      check("sh_addr_hold", dmem_addr, 32'h200);
      check("sh_stall", 32'(stall_mem), 32'd1);
      step();
      check("sh_bubble", 32'(has_inst_wb), 32'd0);
    end
    dmem_gnt = 1'b1;
    settle();
    if (dmem_req) req_cycles++;
    check("sh_be_gnt", 32'(dmem_be), 32'hC);
    check("sh_stall_gnt", 32'(stall_mem), 32'd0);
    step();
    clear_inst();
    check("sh_req_cycles", 32'(req_cycles), 32'd4);
    check("sh_has_inst", 32'(has_inst_wb), 32'd1);
    check("sh_pc", inst_pc_wb, 32'h50);

    // misaligned word load
    set_acc(32'h101, 32'd0, 1'b1, 1'b0, `MASK_W, 1'b0, 32'h60);
    dmem_gnt = 1'b1;
    settle();
    check("mis_req", 32'(dmem_req), 32'd0);
    check("mis_stall", 32'(stall_mem), 32'd0);
    step();
    clear_inst();
    check("mis_flag", 32'(misalign_wb), 32'd1);
    check("mis_reg_write", 32'(reg_write_wb), 32'd0);
    check("mis_has_inst", 32'(has_inst_wb), 32'd1);

    // misaligned half store
    set_acc(32'h203, 32'h1234, 1'b0, 1'b1, `MASK_H, 1'b0, 32'h64);
    settle();
    check("mish_req", 32'(dmem_req), 32'd0);
    check("mish_stall", 32'(stall_mem), 32'd0);
    step();
    clear_inst();
    check("mish_flag", 32'(misalign_wb), 32'd1);

    // reset while waiting for read data, then a late rvalid
    set_acc(32'h10C, 32'd0, 1'b1, 1'b0, `MASK_W, 1'b0, 32'h70);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    settle();
    check("rr_in_resp", 32'(state_dbg), 32'd2);
    rst = 1'b1;
    clear_inst();
    step();
    rst = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h12345678;
    settle();
    check("rr_state", 32'(state_dbg), 32'd0);
    check("rr_stall", 32'(stall_mem), 32'd0);
    check("rr_req", 32'(dmem_req), 32'd0);
    step();
    dmem_rvalid = 1'b0;
    check("rr_has_inst", 32'(has_inst_wb), 32'd0);
    check("rr_reg_write", 32'(reg_write_wb), 32'd0);
    check("rr_mem_data", mem_data_wb, 32'd0);

    // ALU instruction followed by a word load
    has_inst_mem  = 1'b1;
    alu_res_mem   = 32'h1234;
    reg_write_mem = 1'b1;
    rd_addr_mem   = 5'd7;
    inst_pc_mem   = 32'h80;
    settle();
    check("b2b_alu_stall", 32'(stall_mem), 32'd0);
    check("b2b_alu_req", 32'(dmem_req), 32'd0);
    step();
    set_acc(32'h108, 32'd0, 1'b1, 1'b0, `MASK_W, 1'b0, 32'h84);
    dmem_gnt = 1'b1;
    check("b2b_alu_res", alu_res_wb, 32'h1234);
    check("b2b_alu_rd", 32'(rd_addr_wb), 32'd7);
    check("b2b_alu_rw", 32'(reg_write_wb), 32'd1);
    check("b2b_alu_m2r", 32'(mem_to_reg_wb), 32'd0);
    settle();
    check("b2b_ld_stall", 32'(stall_mem), 32'd1);
    step();
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hCAFEF00D;
    check("b2b_bubble", 32'(has_inst_wb), 32'd0);
    settle();
    check("b2b_stall_rv", 32'(stall_mem), 32'd0);
    step();
    clear_inst();
    check("b2b_ld_data", mem_data_wb, 32'hCAFEF00D);
    check("b2b_ld_alu", alu_res_wb, 32'h108);
    check("b2b_ld_pc", inst_pc_wb, 32'h84);
    check("b2b_ld_m2r", 32'(mem_to_reg_wb), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
